// File: rtl/cpu_datapath.sv
// Accumulator CPU datapath: PC, IR, AC, ALU, address mux and 32x8 unified RAM driven by controller strobes.
// Registers update one clock after their strobe; RAM reads have 1-clock latency; no backpressure.
module cpu_datapath #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int OPC_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd,
  input  logic              load_ir,
  input  logic              halt,
  input  logic              inc_pc,
  input  logic              load_ac,
  input  logic              load_pc,
  input  logic              mem_wr,
  input  logic [2:0]        cs,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [OPC_W-1:0]  opcode,
  output logic              zero,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ac,
  output logic              halted
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_AND = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(5);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] alu;
  logic [ADDR_W-1:0] addr;
  logic              run;
  logic              cpu_en;

  // A halt edge, or an already halted CPU, freezes every controller-driven update.
  assign run    = !halted && !halt;
  assign addr   = (cs <= 3'd2) ? pc : ir[ADDR_W-1:0];
  assign opcode = ir[DATA_W-1 -: OPC_W];
  assign zero   = (ac == '0);

  always_comb begin
    alu = ac;
    case (opcode)
      OP_ADD:  alu = ac + rd_data;
      OP_AND:  alu = ac & rd_data;
      OP_XOR:  alu = ac ^ rd_data;
      OP_LDA:  alu = rd_data;
      default: alu = ac;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= '0;
      ac      <= '0;
      ir      <= '0;
      rd_data <= '0;
      halted  <= 1'b0;
      cpu_en  <= 1'b0;
    end else begin
      cpu_en <= 1'b1;
      if (halt) halted <= 1'b1;
      if (run) begin
        if (load_ir) ir <= rd_data;
        if (load_ac) ac <= alu;
        if (load_pc)     pc <= ir[ADDR_W-1:0];
        else if (inc_pc) pc <= pc + ADDR_W'(1);
        if (mem_rd && !mem_wr) rd_data <= mem[addr];
      end
    end
  end

  // RAM is never reset; cpu_en keeps CPU stores out while rst is asserted, preload always wins.
  always_ff @(posedge clk) begin
    if (prog_we)                         mem[prog_addr] <= prog_data;
    else if (mem_wr && run && cpu_en)    mem[addr]      <= ac;
  end
endmodule

// File: tb/tb_cpu_datapath.sv
// Bench for cpu_datapath: acts as the controller and checks against an instruction-level model.
module tb_cpu_datapath;
  logic       clk = 1'b0;
  logic       rst;
  logic       mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr;
  logic [2:0] cs;
  logic       prog_we;
  logic [4:0] prog_addr;
  logic [7:0] prog_data;
  logic [2:0] opcode;
  logic       zero;
  logic [4:0] pc;
  logic [7:0] ac;
  logic       halted;

  int checks = 0;
  int errors = 0;

  // Instruction-level reference state
  logic [7:0] m_mem [32];
  logic [4:0] m_pc;
  logic [7:0] m_ac;
  logic       m_halt;

  localparam int RD = 1, IRL = 2, INC = 4, LAC = 8, LPC = 16, WR = 32, HLT = 64;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_ac;
    logic       exp_z;
  } vec_t;
  vec_t vecs[8];

  cpu_datapath #(.DATA_W(8), .ADDR_W(5), .OPC_W(3)) dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .load_ir(load_ir), .halt(halt),
    .inc_pc(inc_pc), .load_ac(load_ac), .load_pc(load_pc), .mem_wr(mem_wr),
    .cs(cs), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .opcode(opcode), .zero(zero), .pc(pc), .ac(ac), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [2:0] s, input int m);
    cs      = s;
    mem_rd  = (m & RD)  != 0;
    load_ir = (m & IRL) != 0;
    inc_pc  = (m & INC) != 0;
    load_ac = (m & LAC) != 0;
    load_pc = (m & LPC) != 0;
    mem_wr  = (m & WR)  != 0;
    halt    = (m & HLT) != 0;
    tick();
    {mem_rd, load_ir, inc_pc, load_ac, load_pc, mem_wr, halt} = '0;
    cs = 3'd0;
  endtask

  task automatic prog(input logic [4:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
    m_mem[a] = d;
  endtask

  task automatic enter_reset();
    rst = 1'b0;
    tick();
    m_pc = '0; m_ac = '0; m_halt = 1'b0;
  endtask

  // Controller sequence for one instruction, then the model's view of what it should do.
  task automatic run_instr();
    logic [7:0] w;
    logic [2:0] op;
    logic [4:0] a;
    w = m_mem[m_pc]; op = w[7:5]; a = w[4:0];
    cyc(3'd0, 0);
    cyc(3'd1, RD);
    cyc(3'd2, RD | IRL);
    cyc(3'd3, IRL);
    chk("opcode", 32'(opcode), 32'(op));
    if (op == 3'd0)      cyc(3'd4, HLT | INC);
    else if (op == 3'd7) cyc(3'd4, INC | LPC);
    else                 cyc(3'd4, INC);
    cyc(3'd5, (op >= 3'd2 && op <= 3'd5) ? RD : 0);
    cyc(3'd6, (op == 3'd6) ? WR : ((op >= 3'd1 && op <= 3'd5) ? LAC : 0));
    cyc(3'd7, 0);
    case (op)
      3'd0: m_halt = 1'b1;
      3'd2: m_ac = 8'((int'(m_ac) + int'(m_mem[a])) % 256);
      3'd3: m_ac = m_ac & m_mem[a];
      3'd4: m_ac = m_ac ^ m_mem[a];
      3'd5: m_ac = m_mem[a];
      3'd6: m_mem[a] = m_ac;
      default: ;
    endcase
    if (op != 3'd0) m_pc = (op == 3'd7) ? a : 5'((int'(m_pc) + 1) % 32);
    chk("pc", 32'(pc), 32'(m_pc));
    chk("ac", 32'(ac), 32'(m_ac));
    chk("zero", 32'(zero), 32'(m_ac == 8'h00));
    chk("halted", 32'(halted), 32'(m_halt));
  endtask

  initial begin
    rst = 1'b0;
    {mem_rd, load_ir, inc_pc, load_ac, load_pc, mem_wr, halt, prog_we} = '0;
    cs = 3'd0; prog_addr = '0; prog_data = '0;
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;

    vecs[0] = '{3'd2, 8'hF0, 8'h20, 8'h10, 1'b0};
    vecs[1] = '{3'd3, 8'h5A, 8'h0F, 8'h0A, 1'b0};
    vecs[2] = '{3'd4, 8'h5A, 8'h0F, 8'h55, 1'b0};
    vecs[3] = '{3'd5, 8'h5A, 8'h00, 8'h00, 1'b1};
    vecs[4] = '{3'd2, 8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[5] = '{3'd4, 8'h33, 8'h33, 8'h00, 1'b1};
    vecs[6] = '{3'd1, 8'h3C, 8'hC3, 8'h3C, 1'b0};
    vecs[7] = '{3'd6, 8'h81, 8'h44, 8'h81, 1'b0};

    // Reset state
    enter_reset();
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_ac", 32'(ac), 32'h0);
    chk("rst_opcode", 32'(opcode), 32'h0);
    chk("rst_zero", 32'(zero), 32'h1);
    chk("rst_halted", 32'(halted), 32'h0);

    // Fetch of LDA 3 with RAM[3]=0
    prog(5'd0, 8'hA3);
    prog(5'd3, 8'h00);
    rst = 1'b1;
    run_instr();
    chk("fetch_opcode", 32'(opcode), 32'h5);
    chk("fetch_ac", 32'(ac), 32'h00);
    chk("fetch_zero", 32'(zero), 32'h1);

    // ALU table: LDA 20 ; <op> 21
    for (int v = 0; v < 8; v++) begin
      enter_reset();
      prog(5'd0, {3'd5, 5'd20});
      prog(5'd1, {vecs[v].op, 5'd21});
      prog(5'd20, vecs[v].a);
      prog(5'd21, vecs[v].b);
      rst = 1'b1;
      run_instr();
      run_instr();
      chk($sformatf("vec%0d_ac", v), 32'(ac), 32'(vecs[v].exp_ac));
      chk($sformatf("vec%0d_zero", v), 32'(zero), 32'(vecs[v].exp_z));
    end

    // Store then reload: LDA 20 ; STO 9 ; LDA 21 ; LDA 9
    enter_reset();
    prog(5'd0, 8'hB4); prog(5'd1, 8'hC9); prog(5'd2, 8'hB5); prog(5'd3, 8'hA9);
    prog(5'd20, 8'h77); prog(5'd21, 8'h00); prog(5'd9, 8'h00);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) run_instr();
    chk("sto_lda_ac", 32'(ac), 32'h77);

    // PC: JMP 31 (inc+load together), wrap 31->0, then JMP 12
    enter_reset();
    prog(5'd0, 8'hFF); prog(5'd31, 8'h20);
    rst = 1'b1;
    run_instr();
    chk("jmp31_pc", 32'(pc), 32'd31);
    run_instr();
    chk("wrap_pc", 32'(pc), 32'd0);
    prog(5'd0, 8'hEC);
    run_instr();
    chk("jmp12_pc", 32'(pc), 32'd12);

    // Halt: LDA 20 ; HLT 10, then strobes while halted
    enter_reset();
    prog(5'd0, 8'hB4); prog(5'd1, 8'h0A);
    prog(5'd20, 8'h66); prog(5'd10, 8'h11);
    rst = 1'b1;
    run_instr();
    run_instr();
    chk("halt_flag", 32'(halted), 32'h1);
    chk("halt_pc", 32'(pc), 32'd1);
    for (int i = 0; i < 4; i++) cyc(3'd7, RD | IRL | INC | LAC | LPC | WR);
    chk("halted_pc", 32'(pc), 32'd1);
    chk("halted_ac", 32'(ac), 32'h66);
    chk("halted_opcode", 32'(opcode), 32'h0);
    chk("halted_sticky", 32'(halted), 32'h1);
    prog(5'd5, 8'hAB);
    enter_reset();
    chk("rst_clears_halt", 32'(halted), 32'h0);
    prog(5'd0, 8'hA5); prog(5'd1, 8'hAA);
    // A store strobe while reset is held must not reach RAM[0]
    cyc(3'd7, WR);
    rst = 1'b1;
    run_instr();
    chk("prog_while_halted", 32'(ac), 32'hAB);
    run_instr();
    chk("no_wr_while_halted", 32'(ac), 32'h11);

    // Random programs against the model
    for (int p = 0; p < 4; p++) begin
      enter_reset();
      for (int i = 0; i < 32; i++)
        prog(5'(i), {3'($urandom_range(1, 7)), 5'($urandom_range(0, 31))});
      rst = 1'b1;
      for (int n = 0; n < 40; n++) run_instr();
    end

    // Asynchronous reset in the middle of a cycle
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_pc", 32'(pc), 32'h0);
    chk("async_ac", 32'(ac), 32'h0);
    chk("async_opcode", 32'(opcode), 32'h0);
    chk("async_zero", 32'(zero), 32'h1);
    chk("async_halted", 32'(halted), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
